// File: rtl/booth_pkg.sv
// Shared widths and Booth recoding helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int WIDTH  = 8;
  localparam int PWIDTH = 2 * WIDTH;
  localparam int CNT_W  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_e;

  // Radix-2 recoding of the current multiplier bit pair {Q[0], Q_1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/subtract of M into A,
// followed by an arithmetic right shift of {A, Q, Q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W:0]   a_i,
  input  logic [W-1:0] q_i,
  input  logic         q_1_i,
  input  logic [W:0]   m_i,
  output logic [W:0]   a_o,
  output logic [W-1:0] q_o,
  output logic         q_1_o
);

  booth_op_e  op;
  logic [W:0] sum;

  always_comb begin
    op  = booth_decode(q_i[0], q_1_i);
    sum = a_i;
    case (op)
      OP_ADD:  sum = a_i + m_i;
      OP_SUB:  sum = a_i - m_i;
      default: sum = a_i;
    endcase
    // A is one bit wider than the operands, so its MSB is a true sign bit.
    a_o   = {sum[W], sum[W:1]};
    q_o   = {sum[0], q_i[W-1:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mul_shift_reg.sv
// Sequential signed Booth multiplier: load operands, then one Booth step per clock
// for WIDTH clocks; {A[WIDTH-1:0], Q} holds the product afterwards.
module booth_mul_shift_reg
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  parallelIn,
  input  logic [WIDTH-1:0]  Multiplicand,
  input  logic              mode,
  output logic [PWIDTH-1:0] parallelOut
);

  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_1_q, q_1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic             q_1_step;

  booth_step #(.W(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .q_1_i (q_1_q),
    .m_i   (m_q),
    .a_o   (a_step),
    .q_o   (q_step),
    .q_1_o (q_1_step)
  );

  always_comb begin
    m_d   = m_q;
    a_d   = a_q;
    q_d   = q_q;
    q_1_d = q_1_q;
    cnt_d = cnt_q;
    if (mode) begin
      m_d   = {Multiplicand[WIDTH-1], Multiplicand};
      a_d   = '0;
      q_d   = parallelIn;
      q_1_d = 1'b0;
      cnt_d = '0;
    end else if (cnt_q < CNT_W'(WIDTH)) begin
      a_d   = a_step;
      q_d   = q_step;
      q_1_d = q_1_step;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      q_1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      a_q   <= a_d;
      q_q   <= q_d;
      q_1_q <= q_1_d;
      cnt_q <= cnt_d;
    end
  end

  assign parallelOut = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_booth_mul_shift_reg.sv
// Randomised bench for booth_mul_shift_reg: arithmetic model of every partial
// {A,Q} value plus literal product checks on the documented operand pairs.
module tb_booth_mul_shift_reg;

  logic        clk;
  logic        reset;
  logic [7:0]  parallelIn;
  logic [7:0]  Multiplicand;
  logic        mode;
  logic [15:0] parallelOut;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Model state: operands captured at the last load and steps taken since.
  int m_mod = 0;
  int q_mod = 0;
  int k_mod = 0;

  booth_mul_shift_reg dut (
    .clk          (clk),
    .reset        (reset),
    .parallelIn   (parallelIn),
    .Multiplicand (Multiplicand),
    .mode         (mode),
    .parallelOut  (parallelOut)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // After k steps the low k multiplier bits are consumed: the top W+k bits of
  // the output carry M * signed(Q[k-1:0]); the rest are the unconsumed Q bits.
  function automatic logic [15:0] model_out(int m, int q, int k);
    longint     sk;
    longint     pk;
    logic [63:0] v;
    logic [7:0]  qb;
    qb = q[7:0];
    sk = longint'(q & ((1 << k) - 1));
    if (k > 0 && qb[k-1]) sk = sk - (longint'(1) << k);
    pk = longint'(m) * sk;
    v  = 64'(pk <<< (8 - k));
    return v[15:0] | 16'(qb >> k);
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mod = 0; q_mod = 0; k_mod = 0;
    end else if (mode) begin
      m_mod = int'($signed(Multiplicand));
      q_mod = int'(parallelIn);
      k_mod = 0;
    end else if (k_mod < 8) begin
      k_mod = k_mod + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("cycle", parallelOut, model_out(m_mod, q_mod, k_mod));
  end

  task automatic do_load(logic [7:0] q, logic [7:0] m);
    @(negedge clk);
    parallelIn   = q;
    Multiplicand = m;
    mode         = 1'b1;
    @(negedge clk);
    mode         = 1'b0;
    parallelIn   = 8'($urandom);
    Multiplicand = 8'($urandom);
  endtask

  task automatic mul_check(string name, logic [7:0] q, logic [7:0] m, logic [15:0] exp);
    do_load(q, m);
    repeat (8) @(negedge clk);
    check(name, parallelOut, exp);
    $display("mul %0d * %0d -> %h", $signed(q), $signed(m), parallelOut);
  endtask

  initial begin
    logic [7:0]  a, b;
    logic [15:0] p;
    reset = 1'b1; mode = 1'b0; parallelIn = 8'd0; Multiplicand = 8'd0;
    #1 reset = 1'b0;
    #2 check("reset_out", parallelOut, 16'h0000);
    #12 reset = 1'b1;
    chk_en = 1'b1;

    repeat (10) @(negedge clk);
    check("run_no_load", parallelOut, 16'h0000);

    mul_check("v45x36",     8'd45,            8'd36,             16'h0654);
    mul_check("vm87x127",   8'(-87),          8'd127,            16'hD4D7);
    mul_check("vm127xm127", 8'(-127),         8'(-127),          16'h3F01);
    mul_check("vm128xm128", 8'h80,            8'h80,             16'h4000);
    mul_check("vm125x127",  8'(-125),         8'd127,            16'hC1FD);
    mul_check("vm114x0",    8'(-114),         8'd0,              16'h0000);

    repeat (5) @(negedge clk);
    check("hold_after_done", parallelOut, 16'h0000);

    // Async reset in the middle of a run.
    do_load(8'd45, 8'd36);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_rst_mid", parallelOut, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Reload mid-run restarts cleanly.
    do_load(8'd99, 8'd77);
    repeat (3) @(negedge clk);
    mul_check("reload", 8'(-87), 8'd127, 16'hD4D7);
    repeat (3) @(negedge clk);
    check("hold_reload", parallelOut, 16'hD4D7);

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      p = 16'($signed(a) * $signed(b));
      if ($urandom_range(0, 3) == 0) begin
        do_load(8'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 7)) @(negedge clk);
      end
      mul_check("rand_prod", a, b, p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
